// File: rtl/stim_sequencer.sv
// stim_sequencer: replays a loadable table of {x,y,z} vectors, one per HOLD cycles, with start/stop/loop control
module stim_sequencer #(
  parameter int DEPTH = 16,
  parameter int AW = 4,
  parameter int HOLD = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [14:0]   wr_data,
  input  logic [AW:0]   num_vec,
  input  logic          loop,
  input  logic          start,
  input  logic          stop,
  output logic          x,
  output logic [7:0]    y,
  output logic [0:5]    z,
  output logic          vec_valid,
  output logic [AW-1:0] vec_idx,
  output logic          busy,
  output logic          done
);
  localparam int CW = HOLD > 1 ? $clog2(HOLD) : 1;
  localparam logic [CW-1:0] HL = CW'(HOLD - 1);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state;
  logic [14:0] mem [DEPTH];
  logic [CW-1:0] cnt;
  logic [AW:0] n;
  logic [AW:0] nv;
  logic loop_r;
  logic last_idx;
  assign nv = num_vec > (AW+1)'(DEPTH) ? (AW+1)'(DEPTH) : num_vec;
  assign last_idx = {1'b0, vec_idx} == n - 1'b1;
  always_ff @(posedge clk)
    if (wr_en) mem[wr_addr] <= wr_data;
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      {x, y, z} <= '0;
      vec_idx <= '0;
      vec_valid <= 1'b0;
      busy <= 1'b0;
      done <= 1'b0;
      cnt <= '0;
      n <= '0;
      loop_r <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: if (start) begin
          if (nv != '0) begin
            state <= RUN;
            n <= nv;
            loop_r <= loop;
            cnt <= '0;
            vec_idx <= '0;
            {x, y, z} <= mem[0];
            vec_valid <= 1'b1;
            busy <= 1'b1;
          end else begin
            state <= DONE;
            done <= 1'b1;
          end
        end
        RUN: if (stop) begin
          state <= IDLE;
          vec_valid <= 1'b0;
          busy <= 1'b0;
        end else if (cnt != HL) begin
          cnt <= cnt + 1'b1;
        end else begin
          cnt <= '0;
          if (!last_idx) begin
            vec_idx <= vec_idx + 1'b1;
            {x, y, z} <= mem[vec_idx + 1'b1];
          end else if (loop_r) begin
            vec_idx <= '0;
            {x, y, z} <= mem[0];
          end else begin
            state <= DONE;
            done <= 1'b1;
            vec_valid <= 1'b0;
            busy <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_stim_sequencer.sv
// tb_stim_sequencer: checks HOLD=1 and HOLD=3 instances against a time-since-start reference model
module tb_stim_sequencer;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst, wr_en, loop, start, stop;
  logic [3:0] wr_addr;
  logic [14:0] wr_data;
  logic [4:0] num_vec;
  logic x_o [2];
  logic [7:0] y_o [2];
  logic [0:5] z_o [2];
  logic vv_o [2];
  logic [3:0] idx_o [2];
  logic busy_o [2];
  logic done_o [2];
  stim_sequencer #(.DEPTH(16), .AW(4), .HOLD(1)) u0 (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .num_vec(num_vec), .loop(loop), .start(start), .stop(stop),
    .x(x_o[0]), .y(y_o[0]), .z(z_o[0]), .vec_valid(vv_o[0]), .vec_idx(idx_o[0]),
    .busy(busy_o[0]), .done(done_o[0])
  );
  stim_sequencer #(.DEPTH(16), .AW(4), .HOLD(3)) u1 (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .num_vec(num_vec), .loop(loop), .start(start), .stop(stop),
    .x(x_o[1]), .y(y_o[1]), .z(z_o[1]), .vec_valid(vv_o[1]), .vec_idx(idx_o[1]),
    .busy(busy_o[1]), .done(done_o[1])
  );
  logic [14:0] mem_m [16];
  int hold [2] = '{1, 3};
  int ph [2];
  int k [2];
  int n [2];
  bit lp [2];
  logic [14:0] last [2];
  int eidx [2];
  int checks = 0;
  int errors = 0;
  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    for (int h = 0; h < 2; h++) begin
      int nv;
      nv = num_vec > 16 ? 16 : int'(num_vec);
      if (rst) begin
        ph[h] = 0;
        last[h] = '0;
        eidx[h] = 0;
      end else if (ph[h] == 0) begin
        if (start && nv != 0) begin
          ph[h] = 1; k[h] = 0; n[h] = nv; lp[h] = loop; eidx[h] = 0; last[h] = mem_m[0];
        end else if (start) ph[h] = 2;
      end else if (ph[h] == 1) begin
        if (stop) ph[h] = 0;
        else begin
          k[h]++;
          if (!lp[h] && k[h] / hold[h] >= n[h]) ph[h] = 2;
          else if (k[h] % hold[h] == 0) begin
            eidx[h] = (k[h] / hold[h]) % n[h];
            last[h] = mem_m[eidx[h]];
          end
        end
      end else ph[h] = 0;
    end
    if (wr_en) mem_m[wr_addr] = wr_data;
    #1;
    for (int h = 0; h < 2; h++) begin
      chk($sformatf("x%0d", h), 32'(x_o[h]), 32'(last[h][14]));
      chk($sformatf("y%0d", h), 32'(y_o[h]), 32'(last[h][13:6]));
      chk($sformatf("z%0d", h), 32'(z_o[h]), 32'(last[h][5:0]));
      chk($sformatf("vec_valid%0d", h), 32'(vv_o[h]), 32'(ph[h] == 1));
      chk($sformatf("busy%0d", h), 32'(busy_o[h]), 32'(ph[h] == 1));
      chk($sformatf("done%0d", h), 32'(done_o[h]), 32'(ph[h] == 2));
      chk($sformatf("vec_idx%0d", h), 32'(idx_o[h]), 32'(eidx[h]));
    end
  endtask
  task automatic wr(input int a, input logic [14:0] d);
    wr_en = 1'b1; wr_addr = 4'(a); wr_data = d;
    tick();
    wr_en = 1'b0;
  endtask
  task automatic go(input int nv, input bit l);
    num_vec = 5'(nv); loop = l; start = 1'b1;
    tick();
    start = 1'b0;
  endtask
  initial begin
    {rst, wr_en, loop, start, stop} = '0;
    wr_addr = '0; wr_data = '0; num_vec = '0;
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    for (int i = 0; i < 16; i++) wr(i, 15'($urandom));
    wr(0, {1'b1, 8'hA5, 6'b101010});
    wr(1, {1'b0, 8'h3C, 6'b000111});
    wr(2, {1'b1, 8'hFF, 6'b111111});
    go(3, 1'b0);
    repeat (5) tick();
    chk("y_stays_ff", 32'(y_o[0]), 32'h0000_00FF);
    repeat (6) tick();
    go(2, 1'b0);
    repeat (9) tick();
    go(2, 1'b1);
    for (int i = 0; i < 20 && eidx[0] != 1; i++) tick();
    repeat (4) tick();
    stop = 1'b1;
    tick();
    stop = 1'b0;
    repeat (3) tick();
    go(0, 1'b0);
    repeat (2) tick();
    go(20, 1'b0);
    repeat (52) tick();
    go(3, 1'b0);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    go(3, 1'b0);
    repeat (12) tick();
    for (int i = 0; i < 800; i++) begin
      rst = $urandom_range(0, 99) == 0;
      start = $urandom_range(0, 7) == 0;
      stop = $urandom_range(0, 15) == 0;
      loop = 1'($urandom);
      num_vec = 5'($urandom_range(0, 20));
      wr_en = $urandom_range(0, 3) == 0;
      wr_addr = 4'($urandom);
      wr_data = 15'($urandom);
      tick();
    end
    {rst, wr_en, loop, start, stop} = '0;
    repeat (60) tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
